id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised decode stage and ID/EX pipeline register for the MIPS pipeline, with a built-in register bank, load-use hazard detection and multi-cycle bubble insertion. It sits between the IF/ID register and the EX stage. It takes the fetched instruction plus the decoded control vector from the combinational control unit, and presents registered operands, immediate, register addresses and control to EX. Valid-bit bubbles replace the old nop flag, and flush, external stall and self-generated hazard stall have a strict priority.

## Interface
- DW, 32: data/PC width
- NREG, 32: register count (power of two); AW = log2(NREG)
- CW, 16: control vector width
- MEMREAD_BIT, 3: index of the memory-read bit in the control vector
- LOAD_DELAY, 1: bubbles inserted per load-use hazard, 1..3

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  external stall from later stages; hold everything
- flush  in  1  taken jump/branch; squash ID/EX contents
- if_valid  in  1  instruction in ID is real (0 = bubble)
- if_instr  in  32  instruction word
- if_pc  in  DW  PC of instruction in ID
- id_ctrl  in  CW  decoded control for if_instr
- wb_we  in  1  writeback enable
- wb_addr  in  AW  writeback register
- wb_data  in  DW  writeback data
- dbg_addr  in  AW  asynchronous debug read address
- dbg_data  out  DW  register[dbg_addr], combinational
- stall_if  out  1  freeze PC and IF/ID (hazard), combinational
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc  out  DW  registered PC
- ex_ctrl  out  CW  registered control
- ex_rs_data, ex_rt_data  out  DW  registered operands
- ex_imm  out  DW  sign-extended instr[15:0]
- ex_rs, ex_rt, ex_rd  out  AW  instr[25:21], [20:16], [15:11] (low AW bits)

## Operation
- Register bank: write on clock edge when wb_we && wb_addr != 0. Register 0 always reads 0. Reset clears all registers.
- Hazard (combinational): ex_valid && ex_ctrl[MEMREAD_BIT] && if_valid && ex_rt != 0 && (ex_rt == instr[25:21] || ex_rt == instr[20:16]).
- FSM states:
  - RUN: on hazard, load a bubble into EX; if LOAD_DELAY > 1, go to HOLD with cnt = LOAD_DELAY-2, otherwise stay in RUN.
  - HOLD: load a bubble each cycle; when cnt == 0, return to RUN, otherwise decrement cnt.
- stall_if = hazard_in_RUN || state == HOLD, gated to 0 by reset, flush and stall.
- Per-edge priority:
  - reset: all outputs 0, state RUN, cnt 0.
  - flush: ex_valid 0, ex_ctrl 0, state RUN.
  - stall: all ID/EX registers, state and cnt hold.
  - hazard or HOLD: bubble (ex_valid 0, ex_ctrl 0; other fields don't-care, drive 0).
  - otherwise capture: ex_valid = if_valid, ex_ctrl = if_valid ? id_ctrl : 0, operands from bank, pc, imm, addresses.
- Bank writes are not blocked by flush or stall.

## Timing
- Capture latency is 1 cycle, ID to EX.
- Reset value of every registered output is 0, including ex_valid. stall_if is 0 during reset.
- A load-use pair costs exactly LOAD_DELAY bubbles. The dependent instruction is captured on the edge after the last bubble.
- Operands are re-read every stalled cycle, so writebacks during a stall are seen.
- Flush during HOLD aborts the remaining bubbles.
- Reset mid-HOLD returns to RUN.

## Configuration
- REGFILE_BYPASS_EN defined: if wb_we && wb_addr != 0 && wb_addr matches a read address (rs, rt, dbg), the read returns wb_data in the same cycle.
- REGFILE_BYPASS_EN undefined: reads return the pre-write value. Writeback-to-ID forwarding is then the EX stage's job.

## Structure
- Shared package: control-vector bit indices (MEMREAD_BIT and siblings), the bubble control constant (all zeros), and FSM state encoding RUN/HOLD.
- One sub-module, regfile_np, holds the NREG x DW bank with two read ports, one debug port, one write port and the bypass macro. Hazard FSM and ID/EX registers stay in the top.

## Test plan
- Reset: hold reset 2 cycles with if_valid=1 -> all ex_* 0, ex_valid 0, stall_if 0, dbg_data 0 for every address.
- Writeback then read: wb write r5=0xDEADBEEF; next cycle decode an instruction with rs=5 -> ex_rs_data=0xDEADBEEF. Write to r0 -> r0 still reads 0.
- Load-use, LOAD_DELAY=1:
  - Sequence: lw r8 with memread set, then add using rs=8.
  - Required: stall_if high 1 cycle, one bubble (ex_valid=0), add captured on the following edge.
  - Repeat with LOAD_DELAY=3 -> exactly 3 bubbles.
- Flush and stall priority:
  - flush asserted with stall and hazard -> ex_valid=0, state RUN, stall_if 0.
  - stall alone -> ex_* unchanged across 4 cycles.
- Bypass: simultaneous wb r3=0x12345678 and decode with rt=3 -> ex_rt_data=0x12345678 with REGFILE_BYPASS_EN, old value without it.
- Flush mid-HOLD (LOAD_DELAY=3, flush after first bubble) -> next valid instruction captured on the edge after flush deasserts.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the decode stage: control-vector bit map, bubble control
// and the load-use hazard FSM encoding.
package id_stage_pipe_pkg;

  localparam int unsigned CTRL_W = 16;

  localparam int unsigned CTRL_REGWRITE_BIT = 0;
  localparam int unsigned CTRL_MEMTOREG_BIT = 1;
  localparam int unsigned CTRL_MEMWRITE_BIT = 2;
  localparam int unsigned CTRL_MEMREAD_BIT  = 3;
  localparam int unsigned CTRL_BRANCH_BIT   = 4;
  localparam int unsigned CTRL_ALUSRC_BIT   = 5;
  localparam int unsigned CTRL_REGDST_BIT   = 6;
  localparam int unsigned CTRL_JUMP_BIT     = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // Wide enough for LOAD_DELAY-2 with LOAD_DELAY up to 3
  localparam int unsigned CNT_W = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/id_stage_pipe_regfile_np.sv
// NREG x DW register bank: two read ports, one debug read port, one write port.
// REGFILE_BYPASS_EN forwards a same-cycle writeback to every read port.
module regfile_np #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] ra_a_i,
  output logic [DW-1:0] rd_a_o,
  input  logic [AW-1:0] ra_b_i,
  output logic [DW-1:0] rd_b_o,
  input  logic [AW-1:0] ra_dbg_i,
  output logic [DW-1:0] rd_dbg_o
);

  logic [DW-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Register 0 is hardwired to zero regardless of what the bank holds
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == '0) ? '0 : mem_q[a];
`ifdef REGFILE_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == a)) v = wdata_i;
`endif
    return v;
  endfunction

  always_comb rd_a_o   = rd_port(ra_a_i);
  always_comb rd_b_o   = rd_port(ra_b_i);
  always_comb rd_dbg_o = rd_port(ra_dbg_i);

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage and ID/EX register with register bank, load-use hazard FSM
// and LOAD_DELAY bubble insertion. Optional bank bypass via REGFILE_BYPASS_EN.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned NREG        = 32,
  parameter int unsigned CW          = CTRL_W,
  parameter int unsigned MEMREAD_BIT = CTRL_MEMREAD_BIT,
  parameter int unsigned LOAD_DELAY  = 1,
  localparam int unsigned AW         = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          if_valid,
  input  logic [31:0]   if_instr,
  input  logic [DW-1:0] if_pc,
  input  logic [CW-1:0] id_ctrl,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          stall_if,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [CW-1:0] ex_ctrl,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_rd
);

  logic [AW-1:0] rs_c, rt_c, rd_c;
  logic [DW-1:0] rs_data_c, rt_data_c, imm_c;
  logic          hazard_c, bubble_c;
  logic          unused_instr_c;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          ex_valid_q, ex_valid_d;
  logic [DW-1:0] ex_pc_q, ex_pc_d;
  logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DW-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DW-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DW-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0] ex_rs_q, ex_rs_d;
  logic [AW-1:0] ex_rt_q, ex_rt_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;

  assign rs_c           = if_instr[21 +: AW];
  assign rt_c           = if_instr[16 +: AW];
  assign rd_c           = if_instr[11 +: AW];
  assign imm_c          = DW'($signed(if_instr[15:0]));
  assign unused_instr_c = ^if_instr[31:26];

  regfile_np #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (wb_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .ra_a_i   (rs_c),
    .rd_a_o   (rs_data_c),
    .ra_b_i   (rt_c),
    .rd_b_o   (rt_data_c),
    .ra_dbg_i (dbg_addr),
    .rd_dbg_o (dbg_data)
  );

  // Load in EX whose destination is a source of the instruction in ID
  assign hazard_c = ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && if_valid && (ex_rt_q != '0) &&
                    ((ex_rt_q == rs_c) || (ex_rt_q == rt_c));

  assign stall_if = ((state_q == ST_RUN && hazard_c) || (state_q == ST_HOLD)) &&
                    !reset && !flush && !stall;

  // Hazard FSM next state; flush beats stall beats hazard
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bubble_c = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (!stall) begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard_c) begin
            bubble_c = 1'b1;
            if (LOAD_DELAY > 1) begin
              state_d = ST_HOLD;
              cnt_d   = CNT_W'(LOAD_DELAY - 2);
            end
          end
        end
        ST_HOLD: begin
          bubble_c = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // ID/EX next values: squash on flush or bubble, hold on stall, else capture
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    if (flush || (!stall && bubble_c)) begin
      ex_valid_d   = 1'b0;
      ex_pc_d      = '0;
      ex_ctrl_d    = CW'(CTRL_BUBBLE);
      ex_rs_data_d = '0;
      ex_rt_data_d = '0;
      ex_imm_d     = '0;
      ex_rs_d      = '0;
      ex_rt_d      = '0;
      ex_rd_d      = '0;
    end else if (!stall) begin
      ex_valid_d   = if_valid;
      ex_pc_d      = if_pc;
      ex_ctrl_d    = if_valid ? id_ctrl : CW'(CTRL_BUBBLE);
      ex_rs_data_d = rs_data_c;
      ex_rt_data_d = rt_data_c;
      ex_imm_d     = imm_c;
      ex_rs_d      = rs_c;
      ex_rt_d      = rt_c;
      ex_rd_d      = rd_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_ctrl_q    <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one instance with LOAD_DELAY=1 (a_*) and one
// with LOAD_DELAY=3 (b_*), driven by the same stimulus.
module tb_id_stage_pipe;

  logic        clock = 1'b0;
  logic        reset, stall, flush, if_valid, wb_we;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [15:0] id_ctrl;
  logic [4:0]  wb_addr, dbg_addr;

  logic        a_stall_if, a_ex_valid, b_stall_if, b_ex_valid;
  logic [31:0] a_dbg, a_ex_pc, a_ex_rs_data, a_ex_rt_data, a_ex_imm;
  logic [31:0] b_dbg, b_ex_pc, b_ex_rs_data, b_ex_rt_data, b_ex_imm;
  logic [15:0] a_ex_ctrl, b_ex_ctrl;
  logic [4:0]  a_ex_rs, a_ex_rt, a_ex_rd, b_ex_rs, b_ex_rt, b_ex_rd;

  int n_pass = 0;
  int n_chk  = 0;
  logic [31:0] exp_bypass;

  always #5 clock = ~clock;

  id_stage_pipe #(.LOAD_DELAY(1)) u_ld1 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg), .stall_if(a_stall_if),
    .ex_valid(a_ex_valid), .ex_pc(a_ex_pc), .ex_ctrl(a_ex_ctrl),
    .ex_rs_data(a_ex_rs_data), .ex_rt_data(a_ex_rt_data), .ex_imm(a_ex_imm),
    .ex_rs(a_ex_rs), .ex_rt(a_ex_rt), .ex_rd(a_ex_rd)
  );

  id_stage_pipe #(.LOAD_DELAY(3)) u_ld3 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg), .stall_if(b_stall_if),
    .ex_valid(b_ex_valid), .ex_pc(b_ex_pc), .ex_ctrl(b_ex_ctrl),
    .ex_rs_data(b_ex_rs_data), .ex_rt_data(b_ex_rt_data), .ex_imm(b_ex_imm),
    .ex_rs(b_ex_rs), .ex_rt(b_ex_rt), .ex_rd(b_ex_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; wb_we = 1'b0;
    wb_addr = 5'd0; wb_data = 32'h0; dbg_addr = 5'd0;
    if_valid = 1'b1; if_instr = itype(6'h23, 5'd1, 5'd2, 16'h1234);
    if_pc = 32'h44; id_ctrl = 16'h0008;

    // Reset
    tick(); tick();
    chk("rst_a_valid", 32'(a_ex_valid), 32'h0);
    chk("rst_a_pc",    a_ex_pc, 32'h0);
    chk("rst_a_ctrl",  32'(a_ex_ctrl), 32'h0);
    chk("rst_a_imm",   a_ex_imm, 32'h0);
    chk("rst_a_rt",    32'(a_ex_rt), 32'h0);
    chk("rst_b_valid", 32'(b_ex_valid), 32'h0);
    chk("rst_a_stall", 32'(a_stall_if), 32'h0);
    chk("rst_b_stall", 32'(b_stall_if), 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk("rst_dbg", a_dbg, 32'h0);
    end

    // Writeback then read
    tick();
    reset = 1'b0; if_valid = 1'b0; id_ctrl = 16'h0;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 1'b0; if_valid = 1'b1; if_instr = itype(6'h00, 5'd5, 5'd0, 16'h8004);
    if_pc = 32'h100; id_ctrl = 16'h0001; dbg_addr = 5'd5;
    #1 chk("dbg_r5", a_dbg, 32'hDEADBEEF);
    tick();
    chk("wb_valid",   32'(a_ex_valid), 32'h1);
    chk("wb_rs_data", a_ex_rs_data, 32'hDEADBEEF);
    chk("wb_pc",      a_ex_pc, 32'h100);
    chk("wb_ctrl",    32'(a_ex_ctrl), 32'h1);
    chk("wb_imm",     a_ex_imm, 32'hFFFF8004);
    chk("wb_rs",      32'(a_ex_rs), 32'h5);
    chk("wb_rd",      32'(a_ex_rd), 32'h10);
    chk("wb_b_rs_data", b_ex_rs_data, 32'hDEADBEEF);

    // Write to r0 is ignored
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; if_valid = 1'b0;
    tick();
    wb_we = 1'b0; dbg_addr = 5'd0;
    #1 chk("r0_zero", a_dbg, 32'h0);

    // Load-use: lw r8 then add rs=8
    if_valid = 1'b1; if_instr = itype(6'h23, 5'd0, 5'd8, 16'h0010);
    if_pc = 32'h200; id_ctrl = 16'h0008;
    tick();
    chk("lw_valid", 32'(a_ex_valid), 32'h1);
    chk("lw_ctrl",  32'(a_ex_ctrl), 32'h8);
    chk("lw_rt",    32'(a_ex_rt), 32'h8);
    if_instr = itype(6'h00, 5'd8, 5'd0, 16'h4820); if_pc = 32'h204; id_ctrl = 16'h0001;
    #1;
    chk("lu_a_stall0", 32'(a_stall_if), 32'h1);
    chk("lu_b_stall0", 32'(b_stall_if), 32'h1);
    tick();
    chk("lu_a_bub_valid", 32'(a_ex_valid), 32'h0);
    chk("lu_a_bub_ctrl",  32'(a_ex_ctrl), 32'h0);
    chk("lu_a_stall1",    32'(a_stall_if), 32'h0);
    chk("lu_b_bub1",      32'(b_ex_valid), 32'h0);
    chk("lu_b_stall1",    32'(b_stall_if), 32'h1);
    tick();
    chk("lu_a_cap_valid", 32'(a_ex_valid), 32'h1);
    chk("lu_a_cap_pc",    a_ex_pc, 32'h204);
    chk("lu_a_cap_rs",    32'(a_ex_rs), 32'h8);
    chk("lu_b_bub2",      32'(b_ex_valid), 32'h0);
    chk("lu_b_stall2",    32'(b_stall_if), 32'h1);
    tick();
    chk("lu_b_bub3",      32'(b_ex_valid), 32'h0);
    chk("lu_b_stall3",    32'(b_stall_if), 32'h0);
    tick();
    chk("lu_b_cap_valid", 32'(b_ex_valid), 32'h1);
    chk("lu_b_cap_pc",    b_ex_pc, 32'h204);

    // External stall holds everything
    stall = 1'b1; if_instr = itype(6'h00, 5'd1, 5'd2, 16'h0); if_pc = 32'h300; id_ctrl = 16'h0022;
    #1 chk("st_stall_if", 32'(a_stall_if), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_a_pc",    a_ex_pc, 32'h204);
      chk("st_a_ctrl",  32'(a_ex_ctrl), 32'h1);
      chk("st_a_valid", 32'(a_ex_valid), 32'h1);
      chk("st_b_pc",    b_ex_pc, 32'h204);
    end
    stall = 1'b0;

    // Flush beats stall and hazard
    if_instr = itype(6'h23, 5'd0, 5'd8, 16'h0); if_pc = 32'h400; id_ctrl = 16'h0008;
    tick();
    chk("fp_b_lw_ctrl", 32'(b_ex_ctrl), 32'h8);
    if_instr = itype(6'h00, 5'd8, 5'd0, 16'h0); if_pc = 32'h404; id_ctrl = 16'h0001;
    #1 chk("fp_b_haz", 32'(b_stall_if), 32'h1);
    flush = 1'b1; stall = 1'b1;
    #1;
    chk("fp_a_stall_if", 32'(a_stall_if), 32'h0);
    chk("fp_b_stall_if", 32'(b_stall_if), 32'h0);
    tick();
    chk("fp_a_valid", 32'(a_ex_valid), 32'h0);
    chk("fp_a_ctrl",  32'(a_ex_ctrl), 32'h0);
    chk("fp_b_valid", 32'(b_ex_valid), 32'h0);
    chk("fp_b_ctrl",  32'(b_ex_ctrl), 32'h0);
    flush = 1'b0; stall = 1'b0;
    #1 chk("fp_b_stall_after", 32'(b_stall_if), 32'h0);
    tick();
    chk("fp_b_run_valid", 32'(b_ex_valid), 32'h1);
    chk("fp_b_run_pc",    b_ex_pc, 32'h404);

    // Flush after the first of three bubbles
    if_instr = itype(6'h23, 5'd0, 5'd8, 16'h0); if_pc = 32'h500; id_ctrl = 16'h0008;
    tick();
    if_instr = itype(6'h00, 5'd0, 5'd8, 16'h0); if_pc = 32'h504; id_ctrl = 16'h0001;
    tick();
    chk("fh_bub1",   32'(b_ex_valid), 32'h0);
    chk("fh_stall1", 32'(b_stall_if), 32'h1);
    flush = 1'b1;
    tick();
    chk("fh_flushed", 32'(b_ex_valid), 32'h0);
    flush = 1'b0;
    #1 chk("fh_stall_after", 32'(b_stall_if), 32'h0);
    tick();
    chk("fh_cap_valid", 32'(b_ex_valid), 32'h1);
    chk("fh_cap_pc",    b_ex_pc, 32'h504);

    // Reset in the middle of HOLD
    if_instr = itype(6'h23, 5'd0, 5'd8, 16'h0); if_pc = 32'h600; id_ctrl = 16'h0008;
    tick();
    if_instr = itype(6'h00, 5'd8, 5'd0, 16'h0); if_pc = 32'h604; id_ctrl = 16'h0001;
    tick();
    chk("rh_stall_hold", 32'(b_stall_if), 32'h1);
    reset = 1'b1;
    #1 chk("rh_stall_rst", 32'(b_stall_if), 32'h0);
    tick();
    chk("rh_valid_rst", 32'(b_ex_valid), 32'h0);
    reset = 1'b0;
    #1 chk("rh_stall_run", 32'(b_stall_if), 32'h0);
    tick();
    chk("rh_cap_valid", 32'(b_ex_valid), 32'h1);
    chk("rh_cap_pc",    b_ex_pc, 32'h604);

    // Same-cycle writeback and decode of rt=3
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 32'h12345678;
`else
    exp_bypass = 32'hAAAA0003;
`endif
    if_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA0003;
    tick();
    wb_data = 32'h12345678; if_valid = 1'b1; if_instr = itype(6'h00, 5'd0, 5'd3, 16'h0);
    if_pc = 32'h700; id_ctrl = 16'h0001; dbg_addr = 5'd3;
    #1 chk("byp_dbg_same", a_dbg, exp_bypass);
    tick();
    wb_we = 1'b0;
    chk("byp_a_rt_data", a_ex_rt_data, exp_bypass);
    chk("byp_b_rt_data", b_ex_rt_data, exp_bypass);
    #1 chk("byp_dbg_after", a_dbg, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
